// File: rtl/mst_imp_rd_dma.sv
// AXI4-lite read master that walks a 2D rectangle of words and streams it out
// as valid/ready pixels, with a bounded number of words in flight.
module mst_imp_rd_dma #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 8,
    parameter int PITCH_W   = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_axi_arvalid,
    input  logic              mem_axi_arready,
    output logic [ADDR_W-1:0] mem_axi_araddr,
    output logic [2:0]        mem_axi_arprot,
    input  logic              mem_axi_rvalid,
    output logic              mem_axi_rready,
    input  logic [DATA_W-1:0] mem_axi_rdata,
    input  logic [1:0]        mem_axi_rresp,
    input  logic [ADDR_W-1:0] IMP_SRC_BADDR,
    input  logic [PITCH_W-1:0] IMP_ADR_PITCH,
    input  logic [CNT_W-1:0]  IMP_HSIZE,
    input  logic [CNT_W-1:0]  IMP_VSIZE,
    input  logic              IMP_ST,
    output logic              pxl_valid,
    input  logic              pxl_ready,
    output logic [DATA_W-1:0] pxl_data,
    output logic              pxl_eol,
    output logic              pxl_eof,
    output logic              imp_busy,
    output logic              imp_done,
    output logic              imp_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BYTES_PER_WORD = ADDR_W'(DATA_W / 8);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
    localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              r_state;
    logic                r_arvalid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [ADDR_W-1:0]   r_row_base;
    logic [PITCH_W-1:0]  r_pitch;
    logic [CNT_W-1:0]    r_hsize;
    logic [CNT_W-1:0]    r_vsize;
    logic [CNT_W-1:0]    r_ax;
    logic [CNT_W-1:0]    r_ay;
    logic [CNT_W-1:0]    r_rx;
    logic [CNT_W-1:0]    r_ry;
    logic [OCC_W-1:0]    r_inflight;
    logic [OCC_W-1:0]    r_rpend;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [DATA_W-1:0]   r_mem_data [BUF_DEPTH];
    logic                r_mem_eol  [BUF_DEPTH];
    logic                r_mem_eof  [BUF_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [OCC_W-1:0]    r_count;

    logic                w_ar_acc;
    logic                w_push;
    logic                w_pop;
    logic                w_last_col;
    logic                w_last_ar;
    logic                w_eol;
    logic                w_eof;
    logic [OCC_W-1:0]    w_inflight_nxt;
    logic [ADDR_W-1:0]   w_next_row;

    assign w_ar_acc   = r_arvalid & mem_axi_arready;
    // Beats with no matching outstanding AR (e.g. left over from before a reset) are dropped.
    assign w_push     = mem_axi_rvalid & (r_state != S_IDLE) & (r_rpend != '0);
    assign w_pop      = (r_count != '0) & pxl_ready;
    assign w_last_col = (r_ax == r_hsize - ONE_C);
    assign w_last_ar  = w_last_col & (r_ay == r_vsize - ONE_C);
    assign w_eol      = (r_rx == r_hsize - ONE_C);
    assign w_eof      = w_eol & (r_ry == r_vsize - ONE_C);
    assign w_inflight_nxt = r_inflight + OCC_W'(w_ar_acc) - OCC_W'(w_pop);
    assign w_next_row = r_row_base + ADDR_W'(r_pitch);

    assign mem_axi_arvalid = r_arvalid;
    assign mem_axi_araddr  = r_araddr;
    assign mem_axi_arprot  = 3'b000;
    assign mem_axi_rready  = 1'b1;
    assign pxl_valid       = (r_count != '0);
    assign pxl_data        = r_mem_data[r_rd_ptr];
    assign pxl_eol         = pxl_valid & r_mem_eol[r_rd_ptr];
    assign pxl_eof         = pxl_valid & r_mem_eof[r_rd_ptr];
    assign imp_busy        = r_busy;
    assign imp_done        = r_done;
    assign imp_err         = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_row_base <= '0;
            r_pitch    <= '0;
            r_hsize    <= '0;
            r_vsize    <= '0;
            r_ax       <= '0;
            r_ay       <= '0;
            r_rx       <= '0;
            r_ry       <= '0;
            r_inflight <= '0;
            r_rpend    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_inflight_nxt;
            r_rpend    <= r_rpend + OCC_W'(w_ar_acc) - OCC_W'(w_push);
            if (w_push) begin
                if (w_eol) begin
                    r_rx <= '0;
                    r_ry <= r_ry + ONE_C;
                end else begin
                    r_rx <= r_rx + ONE_C;
                end
                if (mem_axi_rresp != 2'b00) r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (IMP_ST) begin
                        r_pitch <= IMP_ADR_PITCH;
                        r_hsize <= IMP_HSIZE;
                        r_vsize <= IMP_VSIZE;
                        if (IMP_HSIZE == '0 || IMP_VSIZE == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                            r_arvalid  <= 1'b1;
                            r_araddr   <= IMP_SRC_BADDR;
                            r_row_base <= IMP_SRC_BADDR;
                            r_ax       <= '0;
                            r_ay       <= '0;
                            r_rx       <= '0;
                            r_ry       <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_ar_acc) begin
                        if (w_last_col) begin
                            r_ax       <= '0;
                            r_ay       <= r_ay + ONE_C;
                            r_row_base <= w_next_row;
                            r_araddr   <= w_next_row;
                        end else begin
                            r_ax     <= r_ax + ONE_C;
                            r_araddr <= r_araddr + BYTES_PER_WORD;
                        end
                        if (w_last_ar) r_state <= S_DRAIN;
                    end
                    // A pending AR can only see inflight fall, so arvalid never drops unaccepted.
                    r_arvalid <= !(w_ar_acc && w_last_ar) && (w_inflight_nxt < DEPTH_C);
                end
                S_DRAIN: begin
                    if (w_pop && pxl_eof) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Return buffer: occupancy is bounded by inflight, so a push never finds it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_eol[i]  <= 1'b0;
                r_mem_eof[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= mem_axi_rdata;
                r_mem_eol[r_wr_ptr]  <= w_eol;
                r_mem_eof[r_wr_ptr]  <= w_eof;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

endmodule
